// File: rtl/proc_input_sequencer.sv
// Plays a loadable image of {hold, word} entries onto the processor data bus,
// showing each word for hold+1 cycles back to back, then returning to IDLE_WORD.
module proc_input_sequencer #(
  parameter int              WIDTH     = 16,
  parameter int              DEPTH     = 16,
  parameter int              ADDR_W    = 4,
  parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [7:0]        wr_hold,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              abort,
  output logic [WIDTH-1:0]  data_out,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] word_idx,
  output logic              wr_rej
);

  typedef enum logic {IDLE, PLAY} state_t;

  localparam logic [ADDR_W-1:0] ONE = 1;

  state_t            state, state_n;
  logic [7:0]        cnt, cnt_n;
  logic [ADDR_W-1:0] last_idx, last_n;
  logic [ADDR_W-1:0] idx_n, idx_inc;
  logic [WIDTH-1:0]  data_n;
  logic              busy_n, done_n;
  logic              start_acc, wr_ok;

  logic [WIDTH-1:0]  mem_word [DEPTH];
  logic [7:0]        mem_hold [DEPTH];

  // Handshake: start is a one-cycle request, taken only in IDLE with a
  // nonzero len and no abort; abort ends PLAY on the next edge and beats
  // everything except reset. Writes land only while IDLE with no start taken.
  assign start_acc = (state == IDLE) && start && !abort && (len != '0);
  assign wr_ok     = wr_en && (state == IDLE) && !start_acc;
  assign idx_inc   = word_idx + ONE;

  // Image storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem_word[wr_addr] <= wr_data;
      mem_hold[wr_addr] <= wr_hold;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = word_idx;
    last_n  = last_idx;
    data_n  = data_out;
    busy_n  = busy;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start_acc) begin
          state_n = PLAY;
          data_n  = mem_word[0];
          cnt_n   = mem_hold[0];
          idx_n   = '0;
          busy_n  = 1'b1;
          // DEPTH is 2**ADDR_W, so any len with the top bit set clamps to DEPTH.
          last_n  = len[ADDR_W] ? '1 : (len[ADDR_W-1:0] - ONE);
        end
      end
      PLAY: begin
        if (abort) begin
          state_n = IDLE;
          data_n  = IDLE_WORD;
          busy_n  = 1'b0;
        end else if (cnt != 8'd0) begin
          cnt_n = cnt - 8'd1;
        end else if (word_idx == last_idx) begin
          state_n = IDLE;
          data_n  = IDLE_WORD;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          idx_n  = idx_inc;
          data_n = mem_word[idx_inc];
          cnt_n  = mem_hold[idx_inc];
        end
      end
      default: begin
        state_n = IDLE;
        data_n  = IDLE_WORD;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      word_idx <= '0;
      last_idx <= '0;
      data_out <= IDLE_WORD;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_rej   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      word_idx <= idx_n;
      last_idx <= last_n;
      data_out <= data_n;
      busy     <= busy_n;
      done     <= done_n;
      wr_rej   <= wr_en && !wr_ok;
    end
  end

endmodule

// File: tb/tb_proc_input_sequencer.sv
// Directed bench for proc_input_sequencer: a cycle-list model of playback is
// compared against the DUT every cycle, plus hand-computed run/length checks.
module tb_proc_input_sequencer;

  localparam int W = 16;
  localparam int D = 16;
  localparam int A = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         wr_en = 1'b0;
  logic [A-1:0] wr_addr = '0;
  logic [W-1:0] wr_data = '0;
  logic [7:0]   wr_hold = '0;
  logic         start = 1'b0;
  logic [A:0]   len = '0;
  logic         abort = 1'b0;
  logic [W-1:0] data_out;
  logic         busy, done, wr_rej;
  logic [A-1:0] word_idx;

  proc_input_sequencer #(.WIDTH(W), .DEPTH(D), .ADDR_W(A), .IDLE_WORD(16'h0000)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_hold(wr_hold), .start(start), .len(len), .abort(abort),
    .data_out(data_out), .busy(busy), .done(done), .word_idx(word_idx), .wr_rej(wr_rej)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- model: list of per-cycle outputs still to be shown ----------------
  typedef struct packed {
    logic [W-1:0] w;
    logic [A-1:0] i;
  } ent_t;

  ent_t         exp_q[$];
  logic [W+7:0] mdl_mem [D];
  logic         exp_done = 1'b0;
  logic         exp_rej = 1'b0;
  bit           idx_zero = 1'b1;
  bit           live = 1'b0;

  always @(posedge clk) begin
    bit   idle_b;
    bit   acc;
    int   n;
    ent_t e;
    live = 1'b1;
    if (rst) begin
      exp_q.delete();
      exp_done = 1'b0;
      exp_rej  = 1'b0;
      idx_zero = 1'b1;
    end else begin
      idle_b   = (exp_q.size() == 0);
      acc      = idle_b && start && !abort && (len != 0);
      exp_done = 1'b0;
      exp_rej  = 1'b0;
      if (!idle_b) begin
        if (abort) exp_q.delete();
        else begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) exp_done = 1'b1;
        end
      end else if (acc) begin
        idx_zero = 1'b0;
        n = (int'(len) > D) ? D : int'(len);
        for (int k = 0; k < n; k++) begin
          e.w = mdl_mem[k][W-1:0];
          e.i = k[A-1:0];
          for (int r = 0; r <= int'(mdl_mem[k][W+7:W]); r++) exp_q.push_back(e);
        end
      end
      if (wr_en) begin
        if (idle_b && !acc) mdl_mem[wr_addr] = {wr_hold, wr_data};
        else exp_rej = 1'b1;
      end
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    if (live) begin
      check("busy", busy, exp_q.size() != 0);
      check("data_out", data_out, (exp_q.size() != 0) ? exp_q[0].w : 16'h0000);
      if (exp_q.size() != 0) check("word_idx", word_idx, exp_q[0].i);
      else if (idx_zero) check("word_idx_reset", word_idx, 0);
      check("done", done, exp_done);
      check("wr_rej", wr_rej, exp_rej);
    end
  end

  // ---------------- trace of what the DUT showed ----------------
  logic [W-1:0] tr_w[$];
  logic [A-1:0] tr_i[$];
  int busy_cnt = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (live && !rst) begin
      if (busy) begin
        busy_cnt++;
        tr_w.push_back(data_out);
        tr_i.push_back(word_idx);
      end
      if (done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_stats();
    tr_w.delete();
    tr_i.delete();
    busy_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic write_entry(input int a, input logic [W-1:0] d, input logic [7:0] h);
    wr_en = 1'b1; wr_addr = a[A-1:0]; wr_data = d; wr_hold = h;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_start(input int l);
    start = 1'b1; len = l[A:0];
    @(negedge clk);
    start = 1'b0; len = '0;
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (busy && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("wait_idle_timeout", busy, 0);
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  logic [W-1:0] ew2 [6] = '{16'h0040, 16'h0155, 16'h0008, 16'h0040, 16'h002A, 16'h0081};
  int           eh2 [6] = '{3, 3, 8, 3, 3, 15};

  initial begin
    logic [W-1:0] rw[$];
    int           rl[$];
    int           c;

    // 1: reset held for two edges, then idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_data", data_out, 16'h0000);
    check("idle_busy", busy, 0);

    // 2: processor program playback
    for (int k = 0; k < 6; k++) write_entry(k, ew2[k], eh2[k][7:0]);
    clear_stats();
    do_start(6);
    wait_idle(100);
    rw.delete(); rl.delete();
    foreach (tr_w[k]) begin
      if (k == 0 || tr_w[k] != tr_w[k-1]) begin
        rw.push_back(tr_w[k]);
        rl.push_back(1);
      end else rl[rl.size()-1]++;
    end
    check("prog_runs", rw.size(), 6);
    for (int k = 0; k < 6 && k < rw.size(); k++) begin
      check("prog_word", rw[k], ew2[k]);
      check("prog_len", rl[k], eh2[k] + 1);
    end
    check("prog_busy_cycles", busy_cnt, 41);
    check("prog_done_count", done_cnt, 1);
    check("prog_end_data", data_out, 16'h0000);

    // 3: zero hold, single entry
    write_entry(0, 16'hBEEF, 8'd0);
    clear_stats();
    do_start(1);
    wait_idle(10);
    check("single_busy_cycles", busy_cnt, 1);
    check("single_word", (tr_w.size() > 0) ? tr_w[0] : 16'h0, 16'hBEEF);
    check("single_done_count", done_cnt, 1);

    // 4: abort on cycle 2 of entry 1
    write_entry(0, 16'h0040, 8'd3);
    write_entry(1, 16'h0155, 8'd3);
    clear_stats();
    do_start(2);
    repeat (5) @(negedge clk);
    check("abort_pre_word", data_out, 16'h0155);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_data", data_out, 16'h0000);
    check("abort_busy", busy, 0);
    @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    clear_stats();
    do_start(2);
    check("replay_first_word", data_out, 16'h0040);
    check("replay_first_idx", word_idx, 0);
    wait_idle(20);

    // 5: rejected write, ignored start while busy, len = 0
    clear_stats();
    do_start(2);
    @(negedge clk);
    write_entry(0, 16'h1111, 8'd0);
    check("rej_pulse", wr_rej, 1);
    do_start(1);
    wait_idle(20);
    check("busy_uninterrupted", busy_cnt, 8);
    check("busy_done_count", done_cnt, 1);
    clear_stats();
    do_start(1);
    wait_idle(20);
    check("entry0_unchanged", (tr_w.size() > 0) ? tr_w[0] : 16'h0, 16'h0040);
    check("entry0_len", tr_w.size(), 4);
    clear_stats();
    do_start(0);
    repeat (3) @(negedge clk);
    check("len0_busy", busy_cnt, 0);
    check("len0_done", done_cnt, 0);

    // 6: clamp len = 31 to 16, then restart in the done cycle
    for (int k = 0; k < 16; k++) write_entry(k, 16'hA000 + 16'(k), 8'd0);
    clear_stats();
    do_start(31);
    c = 0;
    while (!done && c < 40) begin
      @(negedge clk);
      c++;
    end
    check("clamp_done_seen", done, 1);
    check("clamp_words", tr_i.size(), 16);
    for (int k = 0; k < 16 && k < tr_i.size(); k++) check("clamp_idx", tr_i[k], k);
    start = 1'b1; len = 5'd16;
    @(negedge clk);
    start = 1'b0; len = '0;
    check("b2b_busy", busy, 1);
    check("b2b_word", data_out, 16'hA000);
    wait_idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/proc_input_sequencer.md
# proc_input_sequencer

Upstream feeder for the 16-bit `processor` input bus. It holds a small program/data image of words, each with a per-word hold count, and plays it out on `data_out` as a timed word stream for the processor's `data_in`. This replaces hand-timed bench stimulus with a loadable, repeatable sequence. The block sits directly between the loader/host side and `processor.data_in`.

## Interface

Parameters:
- `WIDTH`, 16: data word width; must match the processor `data_in` width.
- `DEPTH`, 16: number of program entries.
- `ADDR_W`, 4: entry address width, equal to log2(`DEPTH`).
- `IDLE_WORD`, 16'h0000: value driven on `data_out` when not playing.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `wr_en`, input, 1: write one entry.
- `wr_addr`, input, ADDR_W: entry index for the write.
- `wr_data`, input, WIDTH: word to store.
- `wr_hold`, input, 8: extra hold cycles for this word. The word is shown for `wr_hold`+1 cycles.
- `start`, input, 1: begin playback of entries 0..`len`-1.
- `len`, input, ADDR_W+1: entry count, sampled only with an accepted `start`.
- `abort`, input, 1: stop playback immediately.
- `data_out`, output, WIDTH: registered word stream; connects to `processor.data_in`.
- `busy`, output, 1: high while playing.
- `done`, output, 1: one-cycle pulse after the last word of a completed playback.
- `word_idx`, output, ADDR_W: index of the entry currently on `data_out`.
- `wr_rej`, output, 1: one-cycle pulse when a write is dropped.

## Operation

Storage:
- DEPTH entries, each holding {hold[7:0], word[WIDTH-1:0]}.
- Storage is not cleared by reset.

Writes:
- Accepted only when IDLE and `start` is not accepted in the same cycle.
- Otherwise the write is dropped and `wr_rej` pulses on the next cycle.

States:
- **IDLE**: `data_out`=IDLE_WORD, `busy`=0.
  - `start` with 1≤`len`≤DEPTH and `abort`=0 → PLAY.
  - `len`>DEPTH is clamped to DEPTH.
  - `len`=0 is ignored, with no `done`.
- **PLAY**: at the start edge, load `data_out`←entry0.word, `cnt`←entry0.hold, `word_idx`←0, `busy`←1. On each later edge:
  - `abort`=1: → IDLE. `data_out`←IDLE_WORD, `busy`←0, no `done`. `abort` has priority over everything else.
  - else if `cnt`≠0: `cnt`←`cnt`-1, `data_out` is held.
  - else if `word_idx`=`len`-1: → IDLE. `data_out`←IDLE_WORD, `busy`←0, `done`←1 for one cycle.
  - else: `word_idx`+1, and load `data_out`/`cnt` from that entry.
- `start` while PLAY is ignored, with no restart.
- `word_idx` and `cnt` never wrap beyond `len`-1.
- `abort` while IDLE has no effect and cancels a same-cycle `start`.

## Timing

Reset values:
- `data_out`=IDLE_WORD, `busy`=0, `done`=0, `word_idx`=0, `wr_rej`=0.
- State IDLE, `cnt`=0.
- Reset mid-playback has the same effect as reset at any other time.
- Reset takes priority over `abort`, `start` and `wr_en`.

Latency:
- `start` sampled at edge T → entry0 on `data_out` and `busy`=1 from T.
- Word k is visible for exactly hold_k+1 cycles.
- Successive words are back-to-back, with no gap cycles.
- Total busy cycles = Σ(hold_k+1).
- IDLE_WORD and `done`=1 appear on the edge after the last word's final cycle.
- A new `start` is accepted in the same cycle `done` is high.

Writes:
- A write at edge T is visible to a `start` at edge T+1 or later.
- `wr_rej` is high for exactly the one cycle following the rejected write.

All outputs are registered; there are no combinational input-to-output paths.

## Test plan

1. **Reset and idle.**
   - Stimulus: assert `rst` 2 cycles, then hold idle.
   - Required response: `data_out`=0x0000, `busy`=0, `done`=0, `word_idx`=0 throughout.
2. **Processor program playback.**
   - Stimulus: load entries 0x0040/h3, 0x0155/h3, 0x0008/h8, 0x0040/h3, 0x002A/h3, 0x0081/h15; `start` with `len`=6.
   - Required response: the words appear in order for 4, 4, 9, 4, 4 and 16 cycles. `busy` is high for 41 cycles. `done` pulses once and `data_out` returns to 0x0000.
   - Also check: the processor's `data_out` matches its single-stepped result.
3. **Zero hold and single entry.**
   - Stimulus: entry0=0xBEEF/h0, `len`=1.
   - Required response: 0xBEEF for exactly 1 cycle, `busy` for 1 cycle, `done` on the next cycle.
4. **Abort mid-word.**
   - Stimulus: `abort` on cycle 2 of a 4-cycle word 0x0155 (entry 1).
   - Required response: next edge gives `data_out`=0x0000, `busy`=0, no `done`. A following `start` replays from entry 0.
5. **Rejected writes and ignored starts.**
   - Stimulus: `wr_en` while busy; `start` while busy; `start` with `len`=0.
   - Required response:
     - `wr_rej` pulses; the entry is unchanged on replay.
     - Playback continues uninterrupted.
     - `len`=0 gives no state change and no `done`.
6. **Clamp and back-to-back.**
   - Stimulus: `len`=31 with all holds 0; then re-`start` in the `done` cycle.
   - Required response: 16 words are played, `word_idx` goes 0..15 without wrap, and the second run begins on the next edge.
